i2s_multi_capture: RTL

Parametrised multi-line I2S receiver with integrated bit-clock/word-select generation, frame decimation and a byte-serialised output stream. It drives `N_LINES` stereo microphone data lines from one shared `i2s_clk`/`i2s_ws` pair. Each kept stereo frame is packed into `OUT_WIDTH`-bit words and presented on a valid/ready stream that feeds the capture FIFO ahead of the SPI readout path. It replaces the single-line capture front end and adds multi-line support, a frame-loss counter and optional frame headers.

---
 rtl/i2s_multi_capture.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_multi_capture.sv
// Multi-line I2S receiver: bit-clock/WS generation, frame decimation and byte-serialised stream output.
// Optional FRAME_HEADER_EN prepends an A5/sequence header pair to each emitted frame.
`timescale 1ns/1ps
module i2s_multi_capture #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int I2S_CLK_FREQ  = 1_500_000,
  parameter int N_LINES       = 2,
  parameter int DATA_SIZE     = 24,
  parameter int SLOT_BITS     = 32,
  parameter int REDUCE_FACTOR = 2,
  parameter int OUT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 i2s_clk,
  output logic                 i2s_ws,
  input  logic [N_LINES-1:0]   i2s_sd,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [15:0]          drop_count,
  output logic                 overflow
);
  localparam int HALF_DIV = CLK_FREQ / (2 * I2S_CLK_FREQ);
  localparam int DIV_W    = $clog2(HALF_DIV + 1);
  localparam int BIT_W    = $clog2(2 * SLOT_BITS);
  localparam int DEC_W    = (REDUCE_FACTOR > 1) ? $clog2(REDUCE_FACTOR) : 1;
  localparam int SAMP_W   = 2 * N_LINES * DATA_SIZE;
`ifdef FRAME_HEADER_EN
  localparam int HDR_W    = 16;
`else
  localparam int HDR_W    = 0;
`endif
  localparam int BUF_W    = SAMP_W + HDR_W;
  localparam int N_WORDS  = BUF_W / OUT_WIDTH;
  localparam int WORD_W   = $clog2(N_WORDS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0]  SLOT_B    = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0]  K_LAST    = BIT_W'(DATA_SIZE);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(REDUCE_FACTOR - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(N_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [DIV_W-1:0]                  div_q;
  logic                              clk_q, ws_q;
  logic [BIT_W-1:0]                  bit_q, bit_nxt, slot_k;
  logic [DEC_W-1:0]                  dec_q;
  logic [N_LINES-1:0]                sync1_q, sync2_q;
  logic [N_LINES-1:0][DATA_SIZE-1:0] left_q, left_d, right_q, right_d;
  logic                              tick, rise, fall, is_right, frame_done, keep;
  logic [SAMP_W-1:0]                 frame_w;
  logic [BUF_W-1:0]                  load_w;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [15:0]       drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              accept, last_word;
`ifdef FRAME_HEADER_EN
  logic [7:0]        seq_q, seq_d;
`endif

  assign tick       = en && (div_q == DIV_LAST);
  assign rise       = tick && !clk_q;
  assign fall       = tick && clk_q;
  assign bit_nxt    = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
  assign is_right   = (bit_q >= SLOT_B);
  assign slot_k     = is_right ? bit_q - SLOT_B : bit_q;
  assign frame_done = rise && (bit_q == BIT_LAST);
  assign keep       = frame_done && (dec_q == '0);

  // Frame image is built from the next-state shift values so a data bit landing on the final slot is kept.
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    frame_w = '0;
    if (rise && (slot_k != '0) && (slot_k <= K_LAST)) begin
      for (int n = 0; n < N_LINES; n++) begin
        if (is_right) right_d[n] = {right_q[n][DATA_SIZE-2:0], sync2_q[n]};
        else          left_d[n]  = {left_q[n][DATA_SIZE-2:0], sync2_q[n]};
      end
    end
    for (int n = 0; n < N_LINES; n++) begin
      frame_w[SAMP_W-1-(2*n)*DATA_SIZE -: DATA_SIZE]   = left_d[n];
      frame_w[SAMP_W-1-(2*n+1)*DATA_SIZE -: DATA_SIZE] = right_d[n];
    end
  end

`ifdef FRAME_HEADER_EN
  assign load_w = {8'hA5, seq_q, frame_w};
`else
  assign load_w = frame_w;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      clk_q   <= 1'b0;
      ws_q    <= 1'b0;
      bit_q   <= '0;
      dec_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      sync1_q <= i2s_sd;
      sync2_q <= sync1_q;
      if (!en) begin
        div_q   <= '0;
        clk_q   <= 1'b0;
        ws_q    <= 1'b0;
        bit_q   <= '0;
        dec_q   <= '0;
        left_q  <= '0;
        right_q <= '0;
      end else begin
        div_q <= tick ? '0 : div_q + 1'b1;
        if (tick) clk_q <= ~clk_q;
        if (fall) begin
          bit_q <= bit_nxt;
          ws_q  <= (bit_nxt >= SLOT_B);
        end
        if (frame_done) dec_q <= (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
        left_q  <= left_d;
        right_q <= right_d;
      end
    end
  end

  assign accept    = (state_q == SEND) && out_ready;
  assign last_word = (state_q == SEND) && (word_q == WORD_LAST);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    buf_d   = buf_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
`ifdef FRAME_HEADER_EN
    seq_d   = seq_q;
`endif
    if (accept) begin
      buf_d  = buf_q << OUT_WIDTH;
      word_d = word_q + 1'b1;
      if (last_word) state_d = IDLE;
    end
    // A frame completing as the last word leaves is latched rather than dropped.
    if (keep) begin
      if (state_q == IDLE || (accept && last_word)) begin
        state_d = SEND;
        buf_d   = load_w;
        word_d  = '0;
`ifdef FRAME_HEADER_EN
        seq_d   = seq_q + 8'd1;
`endif
      end else begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      buf_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef FRAME_HEADER_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      buf_q   <= buf_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
`ifdef FRAME_HEADER_EN
      seq_q   <= seq_d;
`endif
    end
  end

  assign i2s_clk    = clk_q;
  assign i2s_ws     = ws_q;
  assign out_valid  = (state_q == SEND);
  assign out_last   = last_word;
  assign out_data   = buf_q[BUF_W-1 -: OUT_WIDTH];
  assign drop_count = drop_q;
  assign overflow   = ovf_q;
endmodule
